// File: rtl/lsu_mem_port.sv
// ============================================================================
// Module   : lsu_mem_port
// Purpose  : Load/store unit, initiator side of the data-memory port. Takes
//            one request at a time from the memory stage and sign- or
//            zero-extends sub-word loads. Sub-word stores are done as a
//            read-modify-write, because the memory only writes whole 4-byte
//            groups. Each request gets a single-cycle response pulse.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            req_*               - request from pipeline (valid/ready handshake)
//            rsp_*               - one-cycle response pulse (data, error)
//            mem_*               - byte-addressable memory port
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module lsu_mem_port #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_size_i,
  input  logic [AWIDTH-1:0] req_addr_i,
  input  logic [DWIDTH-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  output logic [DWIDTH-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  input  logic [DWIDTH-1:0] mem_data_i,
  input  logic              mem_data_vld_i
);

  localparam logic [2:0] c_SZ_B  = 3'b000;
  localparam logic [2:0] c_SZ_H  = 3'b001;
  localparam logic [2:0] c_SZ_W  = 3'b010;
  localparam logic [2:0] c_SZ_BU = 3'b100;
  localparam logic [2:0] c_SZ_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STORE  = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_ERR    = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [2:0]          r_size;
  logic [AWIDTH-1:0]   r_addr;
  logic [DWIDTH-1:0]   r_wdata;
  logic [DWIDTH-1:0]   r_merged;

  logic                w_accept;
  logic                w_legal;
  logic [DWIDTH-1:0]   w_load_ext;
  logic [DWIDTH-1:0]   w_merge;
  logic                w_rsp_valid;
  logic [DWIDTH-1:0]   w_rsp_rdata;
  logic                w_rsp_err;
  logic                w_mem_rd;
  logic                w_mem_wr;
  logic [AWIDTH-1:0]   w_mem_addr;
  logic [DWIDTH-1:0]   w_mem_data;

  assign req_ready_o = (r_state == ST_IDLE) && !rst;
  assign w_accept    = req_valid_i && req_ready_o;

  // Stores only support B/H/W; loads additionally allow the unsigned forms.
  always_comb begin
    w_legal = 1'b0;
    case (req_size_i)
      c_SZ_B, c_SZ_H, c_SZ_W: w_legal = 1'b1;
      c_SZ_BU, c_SZ_HU:       w_legal = !req_we_i;
      default:                w_legal = 1'b0;
    endcase
  end

  // Load extension, driven by the size captured at accept.
  always_comb begin
    w_load_ext = mem_data_i;
    case (r_size)
      c_SZ_B:  w_load_ext = {{(DWIDTH-8){mem_data_i[7]}},   mem_data_i[7:0]};
      c_SZ_BU: w_load_ext = {{(DWIDTH-8){1'b0}},            mem_data_i[7:0]};
      c_SZ_H:  w_load_ext = {{(DWIDTH-16){mem_data_i[15]}}, mem_data_i[15:0]};
      c_SZ_HU: w_load_ext = {{(DWIDTH-16){1'b0}},           mem_data_i[15:0]};
      default: w_load_ext = mem_data_i;
    endcase
  end

  // Only SB/SH reach RMW, so bit 0 of the size separates half from byte.
  assign w_merge = r_size[0] ? {mem_data_i[DWIDTH-1:16], r_wdata[15:0]}
                             : {mem_data_i[DWIDTH-1:8],  r_wdata[7:0]};

  always_comb begin
    w_next      = r_state;
    w_rsp_valid = 1'b0;
    w_rsp_rdata = '0;
    w_rsp_err   = 1'b0;
    w_mem_rd    = 1'b0;
    w_mem_wr    = 1'b0;
    w_mem_addr  = '0;
    w_mem_data  = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (!w_legal)                   w_next = ST_ERR;
          else if (!req_we_i)             w_next = ST_LOAD;
          else if (req_size_i == c_SZ_W)  w_next = ST_STORE;
          else                            w_next = ST_RMW_RD;
        end
      end
      ST_LOAD: begin
        w_mem_rd    = 1'b1;
        w_mem_addr  = r_addr;
        w_rsp_valid = 1'b1;
        w_rsp_rdata = mem_data_vld_i ? w_load_ext : '0;
        w_rsp_err   = !mem_data_vld_i;
        w_next      = ST_IDLE;
      end
      ST_STORE: begin
        w_mem_wr    = 1'b1;
        w_mem_addr  = r_addr;
        w_mem_data  = r_wdata;
        w_rsp_valid = 1'b1;
        w_next      = ST_IDLE;
      end
      ST_RMW_RD: begin
        w_mem_rd   = 1'b1;
        w_mem_addr = r_addr;
        if (mem_data_vld_i) begin
          w_next = ST_RMW_WR;
        end else begin
          // Read failed: answer with an error and never issue the write.
          w_rsp_valid = 1'b1;
          w_rsp_err   = 1'b1;
          w_next      = ST_IDLE;
        end
      end
      ST_RMW_WR: begin
        w_mem_wr    = 1'b1;
        w_mem_addr  = r_addr;
        w_mem_data  = r_merged;
        w_rsp_valid = 1'b1;
        w_next      = ST_IDLE;
      end
      ST_ERR: begin
        w_rsp_valid = 1'b1;
        w_rsp_err   = 1'b1;
        w_next      = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Memory strobes are blanked during reset, so an aborted RMW can never
  // write, even when reset lands in the write cycle itself.
  assign mem_read_en_o  = w_mem_rd && !rst;
  assign mem_write_en_o = w_mem_wr && !rst;
  assign mem_addr_o     = rst ? '0 : w_mem_addr;
  assign mem_data_o     = rst ? '0 : w_mem_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_size      <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_merged    <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      r_state     <= w_next;
      rsp_valid_o <= w_rsp_valid;
      rsp_rdata_o <= w_rsp_rdata;
      rsp_err_o   <= w_rsp_err;
      if (w_accept) begin
        r_size  <= req_size_i;
        r_addr  <= req_addr_i;
        r_wdata <= req_wdata_i;
      end
      if (r_state == ST_RMW_RD && mem_data_vld_i) begin
        r_merged <= w_merge;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_port.sv
// ============================================================================
// Module   : tb_lsu_mem_port
// Purpose  : Self-checking bench for lsu_mem_port. Contains a byte-array
//            memory model, a response scoreboard (expected data, error flag
//            and response cycle) and a vector table. Hand sequences cover
//            back-to-back issue, busy stalls and reset during RMW.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [2:0]  req_size_i = 3'b000;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_read_en_o;
  logic        mem_write_en_o;
  logic [31:0] mem_data_i;
  logic        mem_data_vld_i = 1'b1;

  always #5 clk = ~clk;

  lsu_mem_port #(.AWIDTH(32), .DWIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_err_o      (rsp_err_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_read_en_o  (mem_read_en_o),
    .mem_write_en_o (mem_write_en_o),
    .mem_data_i     (mem_data_i),
    .mem_data_vld_i (mem_data_vld_i)
  );

  // Memory model: 256 bytes, indexed by the low address byte, little-endian.
  logic [7:0] mem [0:255];
  logic [7:0] a0, a1, a2, a3;
  assign a0 = mem_addr_o[7:0];
  assign a1 = a0 + 8'd1;
  assign a2 = a0 + 8'd2;
  assign a3 = a0 + 8'd3;
  assign mem_data_i = {mem[a3], mem[a2], mem[a1], mem[a0]};

  always @(posedge clk) begin
    if (mem_write_en_o) begin
      mem[a0] <= mem_data_o[7:0];
      mem[a1] <= mem_data_o[15:8];
      mem[a2] <= mem_data_o[23:16];
      mem[a3] <= mem_data_o[31:24];
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          rcyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Response monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (mem_read_en_o)  rd_cnt++;
    if (mem_write_en_o) wr_cnt++;
    chk("rd_wr_exclusive", {31'd0, mem_read_en_o && mem_write_en_o}, 32'd0);
    if (rsp_valid_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata_o, mon_e.rdata);
        chk("rsp_err", {31'd0, rsp_err_o}, {31'd0, mon_e.err});
        chk("rsp_cycle", cyc, mon_e.rcyc);
      end
    end
  end

  // Present a request at a falling edge and hold it until accepted.
  task automatic issue(input logic we, input logic [2:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_err, input int lat, output int acc_cyc);
    exp_t e;
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_size_i  = size;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    acc_cyc     = -1;
    for (int t = 0; t < 20 && acc_cyc < 0; t++) begin
      if (req_ready_o) begin
        acc_cyc = cyc;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.rcyc  = cyc + lat;
        sb.push_back(e);
      end
      @(negedge clk);
    end
    req_valid_i = 1'b0;
    if (acc_cyc < 0) chk("accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    for (int t = 0; t < 20 && sb.size() > 0; t++) @(negedge clk);
    if (sb.size() > 0) begin
      chk("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic        inv;
    int          lat;
    int          rd;
    int          wr;
  } vec_t;

  vec_t vt[17];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int acc;
    int acc_q[4];
    int r0, w0;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h40] = 8'h78; mem[8'h41] = 8'h56; mem[8'h42] = 8'h34; mem[8'h43] = 8'h12;

    //        we    size    addr          wdata         rdata         err  inv  lat rd wr
    vt[0]  = '{1'b1, 3'b010, 32'h01000010, 32'hDEADBEEF, 32'h00000000, 1'b0, 1'b0, 2, 0, 1};
    vt[1]  = '{1'b0, 3'b010, 32'h01000010, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 2, 1, 0};
    vt[2]  = '{1'b1, 3'b000, 32'h01000011, 32'h123456A5, 32'h00000000, 1'b0, 1'b0, 3, 1, 1};
    vt[3]  = '{1'b0, 3'b010, 32'h01000010, 32'h0,        32'hDEADA5EF, 1'b0, 1'b0, 2, 1, 0};
    vt[4]  = '{1'b0, 3'b000, 32'h01000011, 32'h0,        32'hFFFFFFA5, 1'b0, 1'b0, 2, 1, 0};
    vt[5]  = '{1'b0, 3'b100, 32'h01000011, 32'h0,        32'h000000A5, 1'b0, 1'b0, 2, 1, 0};
    vt[6]  = '{1'b0, 3'b001, 32'h01000012, 32'h0,        32'hFFFFDEAD, 1'b0, 1'b0, 2, 1, 0};
    vt[7]  = '{1'b0, 3'b101, 32'h01000012, 32'h0,        32'h0000DEAD, 1'b0, 1'b0, 2, 1, 0};
    vt[8]  = '{1'b0, 3'b011, 32'h01000010, 32'h0,        32'h00000000, 1'b1, 1'b0, 2, 0, 0};
    vt[9]  = '{1'b1, 3'b100, 32'h01000010, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 2, 0, 0};
    vt[10] = '{1'b1, 3'b011, 32'h01000010, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 2, 0, 0};
    vt[11] = '{1'b1, 3'b001, 32'h01000020, 32'hCAFE8001, 32'h00000000, 1'b0, 1'b0, 3, 1, 1};
    vt[12] = '{1'b0, 3'b010, 32'h01000020, 32'h0,        32'h00008001, 1'b0, 1'b0, 2, 1, 0};
    vt[13] = '{1'b0, 3'b001, 32'h01000020, 32'h0,        32'hFFFF8001, 1'b0, 1'b0, 2, 1, 0};
    vt[14] = '{1'b0, 3'b010, 32'h01000010, 32'h0,        32'h00000000, 1'b1, 1'b1, 2, 1, 0};
    vt[15] = '{1'b1, 3'b000, 32'h01000040, 32'h00000011, 32'h00000000, 1'b1, 1'b1, 2, 1, 0};
    vt[16] = '{1'b0, 3'b010, 32'h01000040, 32'h0,        32'h12345678, 1'b0, 1'b0, 2, 1, 0};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset_ready", {31'd0, req_ready_o}, 32'd0);
    chk("reset_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata_o, 32'd0);
    chk("reset_rsp_err", {31'd0, rsp_err_o}, 32'd0);
    chk("reset_mem_en", {30'd0, mem_read_en_o, mem_write_en_o}, 32'd0);
    chk("reset_mem_addr", mem_addr_o, 32'd0);
    chk("reset_mem_data", mem_data_o, 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", {31'd0, req_ready_o}, 32'd1);
    @(negedge clk);

    // Vector table: one request at a time, access counts checked per request.
    for (int i = 0; i < 17; i++) begin
      mem_data_vld_i = !vt[i].inv;
      r0 = rd_cnt;
      w0 = wr_cnt;
      issue(vt[i].we, vt[i].size, vt[i].addr, vt[i].wdata, vt[i].rdata, vt[i].err, vt[i].lat, acc);
      drain();
      mem_data_vld_i = 1'b1;
      chk($sformatf("vec%0d_read_cycles", i), rd_cnt - r0, vt[i].rd);
      chk($sformatf("vec%0d_write_cycles", i), wr_cnt - w0, vt[i].wr);
    end

    // Back-to-back loads with valid held: accepted every second cycle.
    issue(1'b0, 3'b010, 32'h01000010, 32'h0, 32'hDEADA5EF, 1'b0, 2, acc_q[0]);
    issue(1'b0, 3'b100, 32'h01000011, 32'h0, 32'h000000A5, 1'b0, 2, acc_q[1]);
    issue(1'b0, 3'b101, 32'h01000012, 32'h0, 32'h0000DEAD, 1'b0, 2, acc_q[2]);
    issue(1'b0, 3'b010, 32'h01000020, 32'h0, 32'h00008001, 1'b0, 2, acc_q[3]);
    for (int k = 1; k < 4; k++) chk($sformatf("b2b_spacing%0d", k), acc_q[k] - acc_q[k-1], 32'd2);
    drain();

    // SB presented while a load is in flight waits for ready.
    issue(1'b0, 3'b010, 32'h01000010, 32'h0, 32'hDEADA5EF, 1'b0, 2, acc);
    chk("busy_ready_low", {31'd0, req_ready_o}, 32'd0);
    issue(1'b1, 3'b000, 32'h01000013, 32'h00000077, 32'h0, 1'b0, 3, acc_q[0]);
    chk("busy_sb_accept_cycle", acc_q[0] - acc, 32'd2);
    drain();
    issue(1'b0, 3'b010, 32'h01000010, 32'h0, 32'h77ADA5EF, 1'b0, 2, acc);
    drain();

    // Reset during RMW_RD of an SB: no write, no response.
    mem[8'h30] = 8'h99;
    w0 = wr_cnt;
    req_valid_i = 1'b1;
    req_we_i    = 1'b1;
    req_size_i  = 3'b000;
    req_addr_i  = 32'h01000030;
    req_wdata_i = 32'h00000055;
    chk("rst_test_ready", {31'd0, req_ready_o}, 32'd1);
    @(negedge clk);
    req_valid_i = 1'b0;
    chk("rst_test_in_rmw_rd", {31'd0, mem_read_en_o}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_outputs", {28'd0, req_ready_o, rsp_valid_o, mem_read_en_o, mem_write_en_o}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_mid_ready_first_cycle", {31'd0, req_ready_o}, 32'd1);
    repeat (5) @(negedge clk);
    chk("rst_mid_no_write", wr_cnt - w0, 32'd0);
    chk("rst_mid_mem30", {24'd0, mem[8'h30]}, 32'h99);
    chk("rst_mid_mem31", {24'd0, mem[8'h31]}, 32'h00);
    issue(1'b0, 3'b010, 32'h01000030, 32'h0, 32'h00000099, 1'b0, 2, acc);
    drain();

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
